// File: rtl/goertzel_result_collector.sv
// rtl/goertzel_result_collector.sv - Goertzel per-bin result capture, frame freeze and indexed drain
// Collects one result per bin, then streams the frozen set as idx/data words.
module goertzel_result_collector #(
  parameter int NF = 11,
  parameter int DW = 32,
  parameter int IW = $clog2(NF)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NF-1:0]    valid_i,
  input  logic [NF*DW-1:0] data_i,
  input  logic             clr_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IW-1:0]    out_idx,
  output logic [DW-1:0]    out_data,
  output logic             out_last,
  output logic             frame_done,
  output logic [15:0]      frame_cnt,
  output logic             overrun_o,
  output logic             busy
);

  typedef enum logic {S_COLLECT = 1'b0, S_DRAIN = 1'b1} state_e;

  localparam logic [IW-1:0] LAST_IDX = IW'(NF - 1);

  state_e        state_q, state_d;
  logic [NF-1:0] vq_q, mask_q, mask_d, evt;
  logic [DW-1:0] res_q [NF];
  logic [DW-1:0] res_d [NF];
  logic [IW-1:0] rd_ptr_q, rd_ptr_d;
  logic          frame_done_q, frame_done_d;
  logic          overrun_q, overrun_d, ovr_set;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          drain;

  assign evt   = valid_i & ~vq_q;
  assign drain = (state_q == S_DRAIN);

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    res_d        = res_q;
    rd_ptr_d     = rd_ptr_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    ovr_set      = 1'b0;
    if (drain) begin
      // Buffer is frozen while draining; any new result is lost.
      ovr_set = |evt;
      if (out_ready) begin
        if (rd_ptr_q == LAST_IDX) begin
          state_d  = S_COLLECT;
          mask_d   = '0;
          rd_ptr_d = '0;
        end else begin
          rd_ptr_d = rd_ptr_q + IW'(1);
        end
      end
    end else begin
      ovr_set = |(evt & mask_q);
      mask_d  = mask_q | evt;
      for (int k = 0; k < NF; k++) begin
        if (evt[k]) res_d[k] = data_i[k*DW +: DW];
      end
      if (&mask_d) begin
        state_d      = S_DRAIN;
        frame_done_d = 1'b1;
        frame_cnt_d  = frame_cnt_q + 16'd1;
      end
    end
    overrun_d = ovr_set ? 1'b1 : (clr_i ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_COLLECT;
      vq_q         <= '0;
      mask_q       <= '0;
      rd_ptr_q     <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      overrun_q    <= 1'b0;
      for (int k = 0; k < NF; k++) res_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      vq_q         <= valid_i;
      mask_q       <= mask_d;
      rd_ptr_q     <= rd_ptr_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      overrun_q    <= overrun_d;
      res_q        <= res_d;
    end
  end

  assign out_valid  = drain;
  assign busy       = drain;
  assign out_idx    = rd_ptr_q;
  assign out_data   = drain ? res_q[rd_ptr_q] : '0;
  assign out_last   = drain && (rd_ptr_q == LAST_IDX);
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_goertzel_result_collector.sv
// tb/tb_goertzel_result_collector.sv - scoreboard bench for goertzel_result_collector
module tb_goertzel_result_collector;
  localparam int NF = 11;
  localparam int DW = 32;
  localparam int IW = $clog2(NF);

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [NF-1:0]    valid_i = '0;
  logic [NF*DW-1:0] data_i = '0;
  logic             clr_i = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid, out_last, frame_done, overrun_o, busy;
  logic [IW-1:0]    out_idx;
  logic [DW-1:0]    out_data;
  logic [15:0]      frame_cnt;

  goertzel_result_collector #(.NF(NF), .DW(DW), .IW(IW)) dut (
    .clk(clk), .rstn(rstn), .valid_i(valid_i), .data_i(data_i), .clr_i(clr_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_data(out_data), .out_last(out_last), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .overrun_o(overrun_o), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [NF];
  logic [15:0]   exp_cnt = '0;
  int            errors = 0;
  int            checks = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] gen(input int kind, input int k);
    logic [DW-1:0] kk;
    kk = DW'(k);
    case (kind)
      0:       return 32'h1000_0000 + kk;
      1:       return '0 - kk;
      2:       return 32'hA5A5_0000 | (kk * 32'h0000_0111);
      default: return 32'h8000_0000 ^ (kk << 4);
    endcase
  endfunction

  task automatic push_frame();
    exp_t e;
    for (int k = 0; k < NF; k++) begin
      e.idx  = IW'(k);
      e.data = model[k];
      e.last = (k == NF - 1);
      sb.push_back(e);
    end
    exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic load_all(input int kind);
    valid_i = '0;
    step();
    for (int k = 0; k < NF; k++) begin
      model[k] = gen(kind, k);
      data_i[k*DW +: DW] = model[k];
    end
    valid_i = '1;
    step();
    push_frame();
  endtask

  task automatic raise_seq(input int kind, input int again);
    valid_i = '0;
    step();
    for (int k = 0; k < NF; k++) begin
      model[k] = gen(kind, k);
      data_i[k*DW +: DW] = model[k];
      valid_i[k] = 1'b1;
      step();
      if (k == again) begin
        valid_i[k] = 1'b0;
        step();
        model[k] = 32'h0000_0055;
        data_i[k*DW +: DW] = model[k];
        valid_i[k] = 1'b1;
        step();
      end
      if (k < NF - 1) begin
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
          errors++;
          $display("FAIL early_drain bin %0d: busy=%b frame_done=%b want 0 0", k, busy, frame_done);
        end
      end
    end
    push_frame();
  endtask

  task automatic check_start(input string tag);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL %s frame_done: got %b want 1", tag, frame_done);
    end
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b1 || out_idx !== '0) begin
      errors++;
      $display("FAIL %s drain_entry: busy=%b valid=%b idx=%0d want 1 1 0", tag, busy, out_valid, out_idx);
    end
    checks++;
    if (frame_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL %s frame_cnt: got %0d want %0d", tag, frame_cnt, exp_cnt);
    end
  endtask

  task automatic drain(input int pattern, input int stop_at, output int cycles);
    exp_t e;
    cycles = 0;
    while (sb.size() != 0) begin
      if (cycles >= 200) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout: %0d words left want 0", sb.size());
        sb.delete();
        break;
      end
      e = sb[0];
      if (stop_at >= 0 && e.idx == IW'(stop_at)) begin
        out_ready = 1'b0;
        break;
      end
      out_ready = (pattern == 0) || (cycles % 3 == 0);
      checks++;
      if (out_valid !== 1'b1 || out_idx !== e.idx || out_data !== e.data || out_last !== e.last) begin
        errors++;
        $display("FAIL stream: got v=%b idx=%0d data=%h last=%b want v=1 idx=%0d data=%h last=%b",
                 out_valid, out_idx, out_data, out_last, e.idx, e.data, e.last);
      end
      if (out_ready) void'(sb.pop_front());
      step();
      cycles++;
    end
    out_ready = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: valid=%b busy=%b last=%b want 0 0 0", tag, out_valid, busy, out_last);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || out_idx !== '0 || out_data !== '0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_stream: v=%b idx=%0d data=%h last=%b want all 0", out_valid, out_idx, out_data, out_last);
    end
    checks++;
    if (frame_done !== 1'b0 || frame_cnt !== 16'd0 || overrun_o !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: fd=%b cnt=%0d ovr=%b busy=%b want all 0", frame_done, frame_cnt, overrun_o, busy);
    end
    rstn = 1'b1;
    step();
    check_idle("after_reset");
  endtask

  task automatic test_sequential();
    int cyc;
    raise_seq(0, -1);
    check_start("sequential");
    drain(0, -1, cyc);
    checks++;
    if (cyc != NF) begin
      errors++;
      $display("FAIL sequential_cycles: got %0d want %0d", cyc, NF);
    end
    check_idle("sequential");
    checks++;
    if (overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL sequential_overrun: got %b want 0", overrun_o);
    end
  endtask

  task automatic test_all_at_once();
    int cyc;
    load_all(1);
    check_start("all_at_once");
    drain(0, -1, cyc);
    check_idle("all_at_once");
  endtask

  task automatic test_drain_overrun();
    int cyc;
    load_all(2);
    check_start("drain_overrun");
    valid_i[3] = 1'b0;
    step();
    data_i[3*DW +: DW] = 32'hDEAD_BEEF;
    valid_i[3] = 1'b1;
    step();
    checks++;
    if (overrun_o !== 1'b1) begin
      errors++;
      $display("FAIL drain_edge_overrun: got %b want 1", overrun_o);
    end
    valid_i[3] = 1'b0;
    step();
    valid_i[3] = 1'b1;
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    checks++;
    if (overrun_o !== 1'b1) begin
      errors++;
      $display("FAIL set_beats_clear: got %b want 1", overrun_o);
    end
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    checks++;
    if (overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL clear_alone: got %b want 0", overrun_o);
    end
    drain(0, -1, cyc);
    check_idle("drain_overrun");
  endtask

  task automatic test_reraise();
    int cyc;
    raise_seq(3, 2);
    check_start("reraise");
    checks++;
    if (overrun_o !== 1'b1) begin
      errors++;
      $display("FAIL reraise_overrun: got %b want 1", overrun_o);
    end
    drain(0, -1, cyc);
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    checks++;
    if (overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL reraise_clear: got %b want 0", overrun_o);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    load_all(0);
    check_start("backpressure");
    out_ready = 1'b0;
    step();
    checks++;
    if (frame_done !== 1'b0 || out_valid !== 1'b1 || out_idx !== '0) begin
      errors++;
      $display("FAIL backpressure_hold: fd=%b v=%b idx=%0d want 0 1 0", frame_done, out_valid, out_idx);
    end
    drain(1, -1, cyc);
    check_idle("backpressure");
  endtask

  task automatic test_back_to_back();
    int cyc;
    load_all(1);
    check_start("b2b_first");
    valid_i = '0;
    drain(0, -1, cyc);
    for (int k = 0; k < NF; k++) begin
      model[k] = gen(2, k);
      data_i[k*DW +: DW] = model[k];
    end
    valid_i = '1;
    step();
    push_frame();
    check_start("b2b_second");
    drain(0, -1, cyc);
    check_idle("b2b");
  endtask

  task automatic test_reset_mid_drain();
    int cyc;
    load_all(0);
    check_start("mid_reset_pre");
    drain(0, 5, cyc);
    checks++;
    if (out_idx !== IW'(5)) begin
      errors++;
      $display("FAIL mid_reset_position: idx=%0d want 5", out_idx);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_idx !== '0 || out_data !== '0 || out_last !== 1'b0 ||
        frame_done !== 1'b0 || frame_cnt !== 16'd0 || overrun_o !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: v=%b idx=%0d data=%h last=%b fd=%b cnt=%0d ovr=%b busy=%b want all 0",
               out_valid, out_idx, out_data, out_last, frame_done, frame_cnt, overrun_o, busy);
    end
    sb.delete();
    exp_cnt = '0;
    valid_i = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step();
    check_idle("post_reset");
    load_all(2);
    check_start("post_reset");
    drain(0, -1, cyc);
    check_idle("post_reset_done");
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_all_at_once();
    test_drain_overrun();
    test_reraise();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
